// File: rtl/tick_scheduler.sv
// tick_scheduler: shared prescaler driving NUM_CH configurable tick and square-wave channels
module tick_scheduler #(
   parameter int NUM_CH   = 4,
   parameter int CH_IDX_W = 2,
   parameter int PRESCALE = 100_000,
   parameter int PRE_W    = 17,
   parameter int PERIOD_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CH_IDX_W-1:0] cfg_ch,
   input  logic [1:0]          cfg_op,
   input  logic [PERIOD_W-1:0] cfg_period,
   output logic                cfg_err,
   output logic                base_tick,
   output logic [NUM_CH-1:0]   tick,
   output logic [NUM_CH-1:0]   sq,
   output logic [NUM_CH-1:0]   active
);
   logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [NUM_CH-1:0][PERIOD_W-1:0] cnt_q, cnt_d, period_q, period_d;
   logic [NUM_CH-1:0] mode_q, mode_d, active_q, active_d, tick_q, tick_d, sq_q, sq_d;
   logic base_tick_q, base_tick_d, cfg_err_q, cfg_err_d;
   logic upd, xfer, sel;
   always_comb begin
      upd = pre_cnt_q == PRE_W'(PRESCALE - 1);
      xfer = cfg_valid && !upd;
      sel = 1'b0;
      pre_cnt_d = upd ? '0 : pre_cnt_q + 1'b1;
      base_tick_d = upd;
      cfg_err_d = xfer && ({1'b0, cfg_ch} >= (CH_IDX_W + 1)'(NUM_CH));
      cnt_d = cnt_q;
      period_d = period_q;
      mode_d = mode_q;
      active_d = active_q;
      sq_d = sq_q;
      tick_d = '0;
      // Transfers are blocked in the update cycle, so config and counting never overlap
      for (int i = 0; i < NUM_CH; i++) begin
         sel = xfer && cfg_ch == CH_IDX_W'(i);
         if (sel && !cfg_op[1]) begin
            period_d[i] = cfg_period;
            mode_d[i] = cfg_op[0];
            cnt_d[i] = '0;
            active_d[i] = cfg_period != '0;
            cfg_err_d = cfg_err_d | (cfg_period == '0);
         end else if (sel && cfg_op == 2'b10) begin
            cnt_d[i] = '0;
            active_d[i] = 1'b0;
         end else if (sel) begin
            cnt_d[i] = '0;
            active_d[i] = period_q[i] != '0;
            cfg_err_d = cfg_err_d | (period_q[i] == '0);
         end else if (upd && active_q[i]) begin
            tick_d[i] = cnt_q[i] == period_q[i] - PERIOD_W'(1);
            cnt_d[i] = tick_d[i] ? '0 : cnt_q[i] + PERIOD_W'(1);
            sq_d[i] = sq_q[i] ^ tick_d[i];
            active_d[i] = !(tick_d[i] && mode_q[i]);
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt_q <= '0;
         cnt_q <= '0;
         period_q <= '0;
         mode_q <= '0;
         active_q <= '0;
         tick_q <= '0;
         sq_q <= '0;
         base_tick_q <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         pre_cnt_q <= pre_cnt_d;
         cnt_q <= cnt_d;
         period_q <= period_d;
         mode_q <= mode_d;
         active_q <= active_d;
         tick_q <= tick_d;
         sq_q <= sq_d;
         base_tick_q <= base_tick_d;
         cfg_err_q <= cfg_err_d;
      end
   end
   assign cfg_ready = !upd;
   assign cfg_err = cfg_err_q;
   assign base_tick = base_tick_q;
   assign tick = tick_q;
   assign sq = sq_q;
   assign active = active_q;
endmodule

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
- Shares one prescaler counter among NUM_CH software-configurable timing channels.
- Replaces per-consumer divider instances for game timers, blink and animation rates, and move-timeout clocks.
- A host FSM configures each channel's period and mode over a valid/ready port.
- Each channel emits single-cycle tick pulses and a 50%-duty square wave, both in the clk domain.

Parameters:
- NUM_CH, 4, number of channels.
- CH_IDX_W, 2, width of cfg_ch.
- PRESCALE, 100_000, clk cycles per base tick (1 kHz at 100 MHz); must be >= 2.
- PRE_W, 17, prescaler counter width.
- PERIOD_W, 16, channel period width, in base ticks.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  Reset rst_n, asynchronous, active-low.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config can be accepted this cycle.
- cfg_ch  in  CH_IDX_W  target channel.
- cfg_op  in  2  operation: 00 load+periodic, 01 load+oneshot, 10 stop, 11 restart.
- cfg_period  in  PERIOD_W  period in base ticks; used by the load ops only.
- cfg_err  out  1  one-cycle pulse when an accepted request is invalid.
- base_tick  out  1  one-cycle pulse each prescaler wrap.
- tick  out  NUM_CH  one-cycle pulse per channel period.
- sq  out  NUM_CH  toggles on each channel tick.
- active  out  NUM_CH  channel running.

Behaviour:
- Reset values (async): pre_cnt=0; all channel cnt/period/mode=0; active=0, tick=0, sq=0, base_tick=0, cfg_err=0. cfg_ready=1 after reset.
- Prescaler
  - pre_cnt counts 0..PRESCALE-1 and wraps to 0.
  - The update cycle U is any cycle with pre_cnt==PRESCALE-1.
  - base_tick is registered and is high the cycle after U.
- Handshake
  - cfg_ready = (pre_cnt != PRESCALE-1), a combinational decode of the register, so it is low only in U.
  - A transfer occurs when cfg_valid && cfg_ready. Config writes and channel counting therefore never collide.
  - The requester must hold cfg_valid and its payload stable until the transfer.
- Accepted ops (all effects registered at the next edge):
  - 00/01: period<=cfg_period, cnt<=0, mode<=periodic/oneshot, active<=1. If cfg_period==0: active<=0, cnt<=0, cfg_err pulses.
  - 10: active<=0, cnt<=0. sq holds its value; tick is not generated.
  - 11: cnt<=0, active<=1; period and mode kept. If the stored period==0: active stays 0 and cfg_err pulses.
  - cfg_ch >= NUM_CH: no channel state changes; cfg_err pulses.
- Channel update (in cycle U, per channel with active=1):
  - If cnt==period-1: cnt<=0, tick[i]<=1, sq[i]<=~sq[i]. In oneshot mode also active<=0.
  - Otherwise cnt<=cnt+1.
  - All channels update in parallel, so simultaneous terminal counts give simultaneous ticks.
- Tick timing
  - tick is registered and aligned with base_tick; it is 0 in every other cycle.
  - After a load accepted in the prescaler window preceding U_k, the first tick coincides with base_tick following U_(k+period-1). Latency is exactly period base ticks.
  - Period 1 ticks on every base tick.
- Counter width: cnt is PERIOD_W wide, compared against period-1, and never exceeds period-1, so there is no overflow. Maximum period is 2^PERIOD_W-1.
- Inactive channels: cnt frozen at 0 and tick held 0.
- Reset mid-operation: every register returns to its reset value immediately. Counting resumes from pre_cnt=0 after release with all channels inactive.
- cfg_err: registered, one cycle, one pulse per bad request.

Test Plan (sim with PRESCALE=4, PRE_W=2):
1. Reset
   - Stimulus: release rst_n, idle 20 cycles.
   - Required: base_tick every 4th cycle; tick=0, active=0, sq=0; cfg_ready low exactly in cycles with pre_cnt==3.
2. Periodic load
   - Stimulus: load ch0, op00, period=3, accepted at pre_cnt=0.
   - Required: tick[0] pulses with every 3rd base_tick (every 12 clk); sq[0] toggles each pulse; active[0]=1.
3. Oneshot and simultaneous ticks
   - Stimulus: ch1 op01 period=2 and ch2 op00 period=2, loaded in the same window.
   - Required: tick[1] and tick[2] assert in the same cycle; active[1]=0 afterwards; ch2 continues ticking.
4. Backpressure in U
   - Stimulus: assert cfg_valid when pre_cnt==3.
   - Required: no transfer that cycle; transfer occurs the next cycle (pre_cnt=0).
5. Error cases
   - Stimulus: op00 with period=0; op11 on a never-loaded channel; cfg_ch=3 with NUM_CH=3.
   - Required: each yields one cfg_err pulse; active unchanged, or 0 where the op would otherwise have started the channel.
6. Stop and asynchronous reset mid-count
   - Stimulus: stop ch0 mid-period, then assert rst_n low mid-prescale.
   - Required: after the stop, no tick[0] and sq[0] held. On reset, all outputs go to 0 asynchronously; after release, first base_tick comes 4 cycles later.
